bit_serializer: RTL

- Parallel-to-serial front end for the serial sequence detectors in this codebase, including the 1101 Mealy detector.
- Accepts a W-bit word through a valid/ready handshake and shifts it out one bit per bit-period.
- Drives a serial data line plus a per-bit strobe, so a downstream detector can use the strobe as its clock enable / sample point.
- Lets benches and board tests stream known bit patterns into the detectors without hand-toggling the data input.

---
 rtl/detector_pkg.sv | 22 ++
 rtl/bit_period_counter.sv | 30 +++
 rtl/bit_serializer.sv | 113 +++++++++++
 3 files changed

// File: rtl/detector_pkg.sv
// Shared types and helpers for the serial detector front ends.
// Holds the serializer state encoding, a clog2 helper and the default test word.
package detector_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_t;

   localparam logic [3:0] TEST_PATTERN = 4'b1101;

   // Ceiling log2; never returns less than 1 so counters keep a real bit.
   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Bit-period divider: counts DIV clk cycles per bit while run is high.
// Ports: clk, rst (sync, active-high), run, clear -> tick (last cycle of a period).
module bit_period_counter
   import detector_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int CW = clog2_min1(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // With DIV = 1 the count is pinned at 0, so tick follows run.
   assign tick = run && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (run)
         cnt <= tick ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end; optional parity bit with BIT_SERIALIZER_PARITY_EN.
// Ports: clk, rst (sync, active-high), in_data/in_valid/in_ready handshake,
//        ser_data, ser_strobe (sample point), frame_done, busy.
module bit_serializer
   import detector_pkg::*;
#(
   parameter int   W          = 4,
   parameter int   DIV        = 1,
   parameter int   MSB_FIRST  = 1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         ser_data,
   output logic         ser_strobe,
   output logic         frame_done,
   output logic         busy
);

   localparam int IW = clog2_min1(W);
   localparam logic [IW-1:0] LAST_BIT = IW'(W - 1);

   ser_state_t    state, state_nx;
   logic [W-1:0]  shreg;
   logic [IW-1:0] idx;
   logic          tick;
   logic          accept;
   logic          last;
`ifdef BIT_SERIALIZER_PARITY_EN
   logic          par;
`endif

   assign last       = (idx == LAST_BIT);
   assign ser_strobe = tick;

   bit_period_counter #(.DIV(DIV)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .run   (state != IDLE),
      .clear (accept),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Outputs decode registered state only; in_valid reaches accept alone.
   always_comb begin
      state_nx   = state;
      accept     = 1'b0;
      in_ready   = 1'b0;
      busy       = 1'b0;
      ser_data   = IDLE_LEVEL;
      frame_done = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_nx = SHIFT;
         end
         SHIFT: begin
            busy     = 1'b1;
            ser_data = (MSB_FIRST != 0) ? shreg[W-1] : shreg[0];
            if (tick && last) begin
`ifdef BIT_SERIALIZER_PARITY_EN
               state_nx = PARITY;
`else
               frame_done = 1'b1;
               state_nx   = IDLE;
`endif
            end
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         PARITY: begin
            busy     = 1'b1;
            ser_data = par;
            if (tick) begin
               frame_done = 1'b1;
               state_nx   = IDLE;
            end
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   // Bit index saturates at the last bit instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         idx   <= '0;
      end else if (accept) begin
         shreg <= in_data;
         idx   <= '0;
      end else if (state == SHIFT && tick) begin
         shreg <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
         if (!last) idx <= idx + 1'b1;
      end
   end

`ifdef BIT_SERIALIZER_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst)         par <= 1'b0;
      else if (accept) par <= ^in_data;
   end
`endif

endmodule
